// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the single-port SRAM request controller.
package sram_ctrl_pkg;

    localparam int DATA_W_DEF = 80;
    localparam int DEPTH_DEF  = 32;
    localparam int ADDR_W_DEF = 5;

    // Macro pins are active-low.
    localparam logic CEB_ON  = 1'b0;
    localparam logic CEB_OFF = 1'b1;
    localparam logic WEB_WR  = 1'b0;
    localparam logic WEB_RD  = 1'b1;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef enum logic {
        GNT_READ  = 1'b0,
        GNT_WRITE = 1'b1
    } grant_t;

endpackage

// File: rtl/sram_resp_fifo.sv
// Two-entry response FIFO; when empty, incoming data is presented on the
// dequeue side in the same cycle and only stored if it is not taken.
module sram_resp_fifo
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enq_valid,
    input  logic [DATA_W-1:0] enq_data,
    output logic              deq_valid,
    input  logic              deq_ready,
    output logic [DATA_W-1:0] deq_data,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] ent0;
    logic [DATA_W-1:0] ent1;
    logic [1:0]        cnt;
    logic              deq_fire;

    assign count = cnt;

    always_comb begin
        deq_valid = (cnt != 2'd0) || enq_valid;
        deq_data  = (cnt != 2'd0) ? ent0 : enq_data;
        deq_fire  = deq_valid && deq_ready;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt  <= 2'd0;
            ent0 <= '0;
            ent1 <= '0;
        end else begin
            case (cnt)
                2'd0: begin
                    if (enq_valid && !deq_ready) begin
                        ent0 <= enq_data;
                        cnt  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (deq_fire && enq_valid) begin
                        ent0 <= enq_data;
                    end else if (deq_fire) begin
                        cnt <= 2'd0;
                    end else if (enq_valid) begin
                        ent1 <= enq_data;
                        cnt  <= 2'd2;
                    end
                end
                default: begin
                    // Full: the credit counter upstream guarantees no enqueue
                    // arrives without a dequeue in the same cycle.
                    if (deq_fire) begin
                        ent0 <= ent1;
                        if (enq_valid) begin
                            ent1 <= enq_data;
                        end else begin
                            cnt <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/sram_1p_ctrl.sv
// Request-side controller for the single-port SRAM macro: read/write arbitration,
// post-reset zero-fill and a credit-limited, order-preserving read response path.
//   state | meaning
//   INIT  | zero-writing addresses init_ptr = 0..DEPTH-1, requests blocked
//   RUN   | normal read/write service
module sram_1p_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_W        = DATA_W_DEF,
    parameter int DEPTH         = DEPTH_DEF,
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              w_valid,
    output logic              w_ready,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic              r_valid,
    output logic              r_ready,
    input  logic [ADDR_W-1:0] r_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              init_done,
    output logic              sram_ceb,
    output logic              sram_web,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_d,
    input  logic [DATA_W-1:0] sram_q
);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] init_ptr;
    logic [ADDR_W-1:0] init_ptr_nxt;
    grant_t            last_grant;
    grant_t            last_grant_nxt;
    logic [1:0]        occ;
    logic [1:0]        occ_nxt;
    logic              rd_pend;
    logic              rd_credit;
    logic              w_gnt;
    logic              r_gnt;
    logic              resp_fire;
    logic              fifo_valid;
    logic [DATA_W-1:0] fifo_data;
    logic [1:0]        fifo_count;

    assign rd_credit = (occ < 2'd2);

    always_comb begin
        state_nxt      = state;
        init_ptr_nxt   = init_ptr;
        last_grant_nxt = last_grant;
        w_ready        = 1'b0;
        r_ready        = 1'b0;
        init_done      = 1'b0;
        w_gnt          = 1'b0;
        r_gnt          = 1'b0;
        sram_ceb       = CEB_OFF;
        sram_web       = WEB_RD;
        sram_a         = '0;
        sram_d         = '0;
        // Reset gates every pin so the macro sees no access while it is held.
        if (!reset) begin
            case (state)
                INIT: begin
                    sram_ceb     = CEB_ON;
                    sram_web     = WEB_WR;
                    sram_a       = init_ptr;
                    init_ptr_nxt = init_ptr + 1'b1;
                    if (init_ptr == ADDR_W'(DEPTH - 1)) begin
                        state_nxt    = RUN;
                        init_ptr_nxt = '0;
                    end
                end
                RUN: begin
                    init_done = 1'b1;
                    w_ready   = !(r_valid && rd_credit && (last_grant == GNT_WRITE));
                    r_ready   = rd_credit && !(w_valid && (last_grant == GNT_READ));
                    w_gnt     = w_valid && w_ready;
                    r_gnt     = r_valid && r_ready;
                    if (w_gnt) begin
                        sram_ceb = CEB_ON;
                        sram_web = WEB_WR;
                        sram_a   = w_addr;
                        sram_d   = w_data;
                    end else if (r_gnt) begin
                        sram_ceb = CEB_ON;
                        sram_web = WEB_RD;
                        sram_a   = r_addr;
                    end
                    // The round-robin bit only moves on a real conflict.
                    if (w_valid && r_valid && rd_credit) begin
                        last_grant_nxt = w_gnt ? GNT_WRITE : GNT_READ;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        occ_nxt = occ;
        case ({r_gnt, resp_fire})
            2'b10:   occ_nxt = occ + 2'd1;
            2'b01:   occ_nxt = occ - 2'd1;
            default: occ_nxt = occ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= INIT_ON_RESET ? INIT : RUN;
            init_ptr   <= '0;
            last_grant <= GNT_READ;
            occ        <= 2'd0;
            rd_pend    <= 1'b0;
        end else begin
            state      <= state_nxt;
            init_ptr   <= init_ptr_nxt;
            last_grant <= last_grant_nxt;
            occ        <= occ_nxt;
            rd_pend    <= r_gnt;
        end
    end

    // sram_q is only meaningful in the cycle after a read grant.
    sram_resp_fifo #(
        .DATA_W (DATA_W)
    ) u_resp_fifo (
        .clock     (clock),
        .reset     (reset),
        .enq_valid (rd_pend),
        .enq_data  (sram_q),
        .deq_valid (fifo_valid),
        .deq_ready (resp_ready),
        .deq_data  (fifo_data),
        .count     (fifo_count)
    );

    assign resp_valid = !reset && fifo_valid;
    assign resp_data  = resp_valid ? fifo_data : '0;
    assign resp_fire  = resp_valid && resp_ready;

    a_occ_tracks : assert property (@(posedge clock) disable iff (reset)
        occ == (2'(rd_pend) + fifo_count));

endmodule

// File: doc/sram_1p_ctrl.md
# sram_1p_ctrl

Request-side controller for the 32x80 single-port SRAM macro. It sits directly upstream of the macro and has three jobs:
- Arbitrate independent valid/ready read and write request channels onto the macro's active-low CEB/WEB pins.
- Zero-fill the array after reset.
- Return read data on a valid/ready response channel with a 2-entry buffer, so macro output is captured only on true read cycles and never lost under backpressure.

## Interface
Parameters:
- DATA_W, 80, word width
- DEPTH, 32, number of words
- ADDR_W, 5, address width (log2 DEPTH)
- INIT_ON_RESET, 1, zero-fill array after reset when 1

Ports:
- clock  in  1  single clock; one clock domain
- reset  in  1  synchronous, active-high
- w_valid  in  1  write request valid
- w_ready  out  1  write accepted when w_valid && w_ready
- w_addr  in  ADDR_W  write address
- w_data  in  DATA_W  write data
- r_valid  in  1  read request valid
- r_ready  out  1  read accepted when r_valid && r_ready
- r_addr  in  ADDR_W  read address
- resp_valid  out  1  read data valid
- resp_ready  in  1  consumer accepts resp_data
- resp_data  out  DATA_W  read data, returned in request order
- init_done  out  1  high once the array is usable
- sram_ceb  out  1  macro chip enable, active-low
- sram_web  out  1  macro write enable, active-low (0 = write)
- sram_a  out  ADDR_W  macro address
- sram_d  out  DATA_W  macro write data
- sram_q  in  DATA_W  macro read data; valid only in the cycle after a read was issued

## Operation
- FSM states:
  - INIT: walk init_ptr from 0 to DEPTH-1, one zero-write per cycle (ceb=0, web=0, d=0). Go to RUN after writing DEPTH-1.
  - RUN: normal service.
- Reset enters INIT if INIT_ON_RESET=1, otherwise RUN.
- In INIT: w_ready=0, r_ready=0, init_done=0.
- In RUN: init_done=1.
- Pin encoding:
  - Grant write: ceb=0, web=0, a=w_addr, d=w_data.
  - Grant read: ceb=0, web=1, a=r_addr.
  - No grant: ceb=1, web=1, a=0, d=0.
- Only one operation is granted per cycle.
- Arbitration when both r_valid and w_valid are high: round-robin using a last_grant bit. Write wins the first conflict after reset. A single requester is granted immediately, subject to the credit rule below.
- Credit counter occ (0..2) counts reads in flight plus entries held in the buffer.
  - Increment on read grant; decrement on resp fire. Both in the same cycle: no change.
  - r_ready = RUN && occ<2 && read wins the arbitration. w_ready = RUN && write wins.
  - Credit check does not depend on resp_ready, so there is no combinational path from resp_ready to r_ready.
- Response path uses sub-module sram_resp_fifo (2 entries).
  - Capture sram_q in the cycle after a read grant, and only in that cycle. sram_q is ignored on every other cycle.
  - Bypass: if the FIFO is empty, the capture cycle drives resp_valid=1 and resp_data=sram_q directly. If resp_ready is also high, nothing is enqueued.
- Ordering: a write granted in cycle N followed by a read of the same address in cycle N+1 or later returns the new data.

## Timing
- Reset values: w_ready=0, r_ready=0, resp_valid=0, resp_data=0, init_done=0, sram_ceb=1, sram_web=1, sram_a=0, sram_d=0. Also occ=0, FIFO empty, last_grant=read.
- INIT takes DEPTH cycles (32). init_done rises in the first RUN cycle, which is cycle 33 after reset deasserts.
- With INIT_ON_RESET=0, init_done rises in the first cycle after reset deasserts.
- Read latency: accept in cycle N gives resp_valid in cycle N+1, via bypass when the FIFO is empty.
- Sustained throughput with resp_ready=1: one read per cycle.
- With resp_ready=0: at most 2 reads accepted, then r_ready=0 until a response fires.
- Write: accepted in cycle N, committed at the clock edge ending cycle N. No response is returned.
- Reset asserted mid-operation: in-flight read is discarded, FIFO is flushed, occ=0, and INIT restarts from address 0 on the next cycle.
- resp_data is stable while resp_valid && !resp_ready.

## Structure
- Shared package sram_ctrl_pkg holds:
  - state typedef {INIT, RUN}
  - DATA_W/ADDR_W/DEPTH defaults
  - pin-encoding constants CEB_ON=0, WEB_WR=0
- Sub-module sram_resp_fifo: 2-entry FIFO with empty-bypass, ports enq_valid/enq_data/deq_valid/deq_ready/deq_data/count.

## Test plan
- Reset, run 32 cycles, then read addresses 0, 17, 31 -> init_done rises at cycle 33; each read returns 0 one cycle after accept.
- Write addr 5 = 0x1234 in cycle N, read addr 5 in cycle N+1 -> resp_data=0x1234 in cycle N+2. Write addr 5 and read addr 5 both presented in one cycle -> the write is granted first (first conflict after reset), the read follows next cycle and returns the new data.
- r_valid and w_valid held high for 6 cycles -> grants alternate W,R,W,R,W,R; never both in one cycle; sram_ceb=0 every cycle.
- resp_ready=0, issue 3 reads -> 2 accepted, r_ready=0 afterwards. Raise resp_ready -> both responses delivered in order, then the third read is accepted.
- Drive sram_q to 0xDEAD on idle and write cycles -> resp_valid stays 0; no spurious entry is enqueued.
- Assert reset in the cycle after a read grant -> no response ever appears, sram_ceb=1 during reset, INIT zero-writes restart at address 0.
